// File: rtl/muldiv_seq_ctrl.sv
// Sequencer for the shared mult/div unit: start pulses, completion wait, Hi/Lo commit.
// Optional MULDIV_DIVM_EN routes MDR to both div operands for op=10.
module muldiv_seq_ctrl #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_TIMEOUT = 63,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       div_end,
  input  logic       DIVQ,
  output logic       mult_ctrl,
  output logic       div_ctrl,
  output logic       DIVASelect,
  output logic       DIVBSelect,
  output logic       MDSelect,
  output logic       HiCtrl,
  output logic       LoCtrl,
  output logic       busy,
  output logic       done,
  output logic       div_zero,
  output logic       timeout
);

  typedef enum logic [2:0] {
    IDLE,
    MUL_RUN,
    DIV_RUN,
    WRITE,
    FIN
  } state_t;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LIM  = CNT_W'(DIV_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mul_q, mul_d;
  logic             zero_q, zero_d;
  logic             to_q, to_d;
  logic             cnt_sat;

`ifdef MULDIV_DIVM_EN
  logic             divm_q, divm_d;
`endif

  assign cnt_sat = (cnt_q == CNT_MAX);

  // State, counter and latched op/abort flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      zero_q  <= 1'b0;
      to_q    <= 1'b0;
`ifdef MULDIV_DIVM_EN
      divm_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
      zero_q  <= zero_d;
      to_q    <= to_d;
`ifdef MULDIV_DIVM_EN
      divm_q  <= divm_d;
`endif
    end
  end

  // Next state: accept command, count run cycles, pick commit or abort
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
    zero_d  = zero_q;
    to_d    = to_q;
`ifdef MULDIV_DIVM_EN
    divm_d  = divm_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && op != 2'b11) begin
          mul_d  = (op == 2'b00);
          zero_d = 1'b0;
          to_d   = 1'b0;
          cnt_d  = '0;
`ifdef MULDIV_DIVM_EN
          divm_d = (op == 2'b10);
`endif
          state_d = (op == 2'b00) ? MUL_RUN : DIV_RUN;
        end
      end
      MUL_RUN: begin
        if (!cnt_sat) cnt_d = cnt_q + 1'b1;
        if (cnt_q == MUL_LAST) state_d = WRITE;
      end
      DIV_RUN: begin
        if (!cnt_sat) cnt_d = cnt_q + 1'b1;
        if (DIVQ) begin
          zero_d  = 1'b1;
          state_d = FIN;
        end else if (div_end) begin
          state_d = WRITE;
        end else if (cnt_q == DIV_LIM) begin
          to_d    = 1'b1;
          state_d = FIN;
        end
      end
      WRITE:   state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode from state, counter and latched op/flags
  always_comb begin
    mult_ctrl  = (state_q == MUL_RUN) && (cnt_q == '0);
    div_ctrl   = (state_q == DIV_RUN) && (cnt_q == '0);
    busy       = (state_q != IDLE);
    MDSelect   = (state_q != IDLE) && mul_q;
    HiCtrl     = (state_q == WRITE);
    LoCtrl     = (state_q == WRITE);
    done       = (state_q == FIN);
    div_zero   = (state_q == FIN) && zero_q;
    timeout    = (state_q == FIN) && to_q;
`ifdef MULDIV_DIVM_EN
    DIVASelect = (state_q == DIV_RUN) && divm_q;
    DIVBSelect = (state_q == DIV_RUN) && divm_q;
`else
    DIVASelect = 1'b0;
    DIVBSelect = 1'b0;
`endif
  end

endmodule
